button_conditioner: RTL and testbench

//  Front-end conditioner for the five board push-buttons ahead of the CPU core and IO_module.
//  Per button: synchronise the raw pin, debounce it, and produce a clean level plus rise/fall pulses.
//  Per button it also keeps a sticky "event pending" flag that the CPU clears through an explicit

---
 rtl/button_conditioner_pkg.sv | 21 ++
 rtl/button_conditioner_debounce_channel.sv | 122 ++++++++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button front end: clock/debounce timing,
// button index map and the per-channel debounce state codes.
package button_conditioner_pkg;

  localparam int unsigned CLK_HZ            = 32'd23_000_000;
  localparam int unsigned DEBOUNCE_MS       = 32'd20;
  localparam int unsigned DB_CYCLES_DEFAULT = (CLK_HZ / 32'd1000) * DEBOUNCE_MS;

  localparam int unsigned BTN_ENTER_B  = 32'd0;
  localparam int unsigned BTN_ENTER_A  = 32'd1;
  localparam int unsigned BTN_START_PG = 32'd2;
  localparam int unsigned BTN_ENTER    = 32'd3;
  localparam int unsigned BTN_SPARE    = 32'd4;

  // Bit 1 of the state code equals the debounced level.
  localparam logic [1:0] ST_REL     = 2'd0;
  localparam logic [1:0] ST_REL_CHK = 2'd1;
  localparam logic [1:0] ST_PRS     = 2'd2;
  localparam logic [1:0] ST_PRS_CHK = 2'd3;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: synchroniser, debounce FSM with stability counter,
// registered level/rise/fall and the sticky software-visible pending flag.
module button_conditioner_debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 32'd2,
  parameter int unsigned DB_CYCLES   = 32'd460000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  input  logic evt_ack,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic evt_pending
);

  localparam int unsigned      CNT_W    = $clog2(DB_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 32'd1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sample_s;
  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   done_s;
  logic                   level_nxt_s;
  logic                   rise_nxt_s;
  logic                   fall_nxt_s;
  logic                   pend_nxt_s;

  assign sample_s = sync_r[SYNC_STAGES-1];
  // ">=" rather than "==" so DB_CYCLES==1 accepts on its first CHK cycle instead of wrapping.
  assign done_s   = (cnt_r >= CNT_LAST);

  // Next-state, counter and output-pulse decode for the debounce FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    level_nxt_s = btn_level;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    pend_nxt_s  = 1'b0;
    case (state_r)
      ST_REL: begin
        if (sample_s) begin
          state_nxt_s = ST_REL_CHK;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_REL_CHK: begin
        if (!sample_s) begin
          state_nxt_s = ST_REL;
          cnt_nxt_s   = CNT_ZERO;
        end else if (done_s) begin
          state_nxt_s = ST_PRS;
          cnt_nxt_s   = CNT_ZERO;
          level_nxt_s = 1'b1;
          rise_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_PRS: begin
        if (!sample_s) begin
          state_nxt_s = ST_PRS_CHK;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_PRS_CHK: begin
        if (sample_s) begin
          state_nxt_s = ST_PRS;
          cnt_nxt_s   = CNT_ZERO;
        end else if (done_s) begin
          state_nxt_s = ST_REL;
          cnt_nxt_s   = CNT_ZERO;
          level_nxt_s = 1'b0;
          fall_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_REL;
        cnt_nxt_s   = CNT_ZERO;
        level_nxt_s = 1'b0;
      end
    endcase
    // A new press in the same cycle as an ack wins, so that press is not lost.
    pend_nxt_s = rise_nxt_s | (evt_pending & ~evt_ack);
  end

  // Synchroniser, FSM state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r      <= {SYNC_STAGES{1'b0}};
      state_r     <= ST_REL;
      cnt_r       <= CNT_ZERO;
      btn_level   <= 1'b0;
      btn_rise    <= 1'b0;
      btn_fall    <= 1'b0;
      evt_pending <= 1'b0;
    end else begin
      sync_r      <= {sync_r[SYNC_STAGES-2:0], btn_raw};
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      btn_level   <= level_nxt_s;
      btn_rise    <= rise_nxt_s;
      btn_fall    <= fall_nxt_s;
      evt_pending <= pend_nxt_s;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: one independent debounce channel per board button;
// this level only fans the vectors out to the channels.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned N_BTN       = 32'd5,
  parameter int unsigned SYNC_STAGES = 32'd2,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [N_BTN-1:0] evt_pending,
  input  logic [N_BTN-1:0] evt_ack
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_conditioner_debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .evt_ack     (evt_ack[i]),
      .btn_level   (btn_level[i]),
      .btn_rise    (btn_rise[i]),
      .btn_fall    (btn_fall[i]),
      .evt_pending (evt_pending[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_button_conditioner;

  localparam int N    = 5;
  localparam int SYNC = 2;
  localparam int DB   = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] evt_ack;
  logic [4:0] btn_level;
  logic [4:0] btn_rise;
  logic [4:0] btn_fall;
  logic [4:0] evt_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  button_conditioner #(
    .N_BTN       (N),
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_rise    (btn_rise),
    .btn_fall    (btn_fall),
    .evt_pending (evt_pending),
    .evt_ack     (evt_ack)
  );

  // Model: a change is accepted once the synchronised input has differed from the
  // current level for DB consecutive samples.
  logic [4:0] m_dly [SYNC];
  logic [4:0] m_level, m_rise, m_fall, m_pend;
  int         m_run [N];

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SYNC; k++) m_dly[k] <= '0;
      m_level <= '0; m_rise <= '0; m_fall <= '0; m_pend <= '0;
      for (int i = 0; i < N; i++) m_run[i] <= 0;
    end else begin
      m_dly[0] <= btn_raw;
      for (int k = 1; k < SYNC; k++) m_dly[k] <= m_dly[k-1];
      for (int i = 0; i < N; i++) begin
        automatic int   run = m_run[i];
        automatic logic lv  = m_level[i];
        automatic logic r   = 1'b0;
        automatic logic f   = 1'b0;
        if (m_dly[SYNC-1][i] != lv) run = run + 1;
        else run = 0;
        if (run == DB) begin
          lv  = ~lv;
          r   = lv;
          f   = ~lv;
          run = 0;
        end
        m_level[i] <= lv;
        m_rise[i]  <= r;
        m_fall[i]  <= f;
        m_run[i]   <= run;
        m_pend[i]  <= r | (m_pend[i] & ~evt_ack[i]);
      end
    end
  end

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("model_level", btn_level, m_level);
    check("model_rise", btn_rise, m_rise);
    check("model_fall", btn_fall, m_fall);
    check("model_pending", evt_pending, m_pend);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 5'h1F;
    evt_ack = 5'h00;

    // 1: reset with all buttons held
    repeat (3) begin
      @(negedge clock);
      check("t1_rst_level", btn_level, 5'h00);
      check("t1_rst_rise", btn_rise, 5'h00);
      check("t1_rst_pend", evt_pending, 5'h00);
    end
    reset = 1'b0;
    tick(9);  check("t1_level_early", btn_level, 5'h00);
    tick(1);  check("t1_level", btn_level, 5'h1F);
              check("t1_rise", btn_rise, 5'h1F);
              check("t1_pend", evt_pending, 5'h1F);
    tick(1);  check("t1_rise_1cyc", btn_rise, 5'h00);
    btn_raw = 5'h00;
    tick(9);  check("t1_rel_early", btn_level, 5'h1F);
    tick(1);  check("t1_fall", btn_fall, 5'h1F);
              check("t1_rel_level", btn_level, 5'h00);
    evt_ack = 5'h1F; tick(1); evt_ack = 5'h00;
    check("t1_ack", evt_pending, 5'h00);

    // 2: clean press on ch0
    btn_raw = 5'b00001;
    tick(9);  check("t2_level_early", btn_level, 5'h00);
    tick(1);  check("t2_level", btn_level, 5'b00001);
              check("t2_rise", btn_rise, 5'b00001);
              check("t2_pend", evt_pending, 5'b00001);
    tick(10); btn_raw = 5'h00;
    tick(9);  check("t2_fall_early", btn_fall, 5'h00);
    tick(1);  check("t2_fall", btn_fall, 5'b00001);
              check("t2_pend_kept", evt_pending, 5'b00001);
    evt_ack = 5'b00001; tick(1); evt_ack = 5'h00;
    check("t2_ack", evt_pending, 5'h00);

    // 3: bouncing ch1
    for (int k = 0; k < 5; k++) begin
      btn_raw[1] = 1'b1;
      repeat (3) begin tick(1); check("t3_bounce_rise", btn_rise, 5'h00); end
      btn_raw[1] = 1'b0;
      repeat (3) begin tick(1); check("t3_bounce_rise", btn_rise, 5'h00); end
    end
    btn_raw[1] = 1'b1;
    tick(9);  check("t3_rise_early", btn_rise, 5'h00);
    tick(1);  check("t3_rise", btn_rise, 5'b00010);
    btn_raw[1] = 1'b0;
    tick(10); check("t3_fall", btn_fall, 5'b00010);
    evt_ack = 5'b00010; tick(1); evt_ack = 5'h00;

    // 4: ack racing a new press on ch2
    btn_raw[2] = 1'b1;
    tick(10); check("t4_rise1", btn_rise, 5'b00100);
    btn_raw[2] = 1'b0;
    tick(10); check("t4_fall1", btn_fall, 5'b00100);
    tick(2);  check("t4_pend_held", evt_pending, 5'b00100);
    btn_raw[2] = 1'b1;
    tick(9);  evt_ack = 5'b00100;
    tick(1);  check("t4_rise2", btn_rise, 5'b00100);
              check("t4_set_wins", evt_pending, 5'b00100);
    tick(1);  check("t4_ack_clears", evt_pending, 5'h00);
    evt_ack = 5'b10000;
    tick(1);  check("t4_ack_idle", evt_pending, 5'h00);
    evt_ack = 5'h00;
    btn_raw[2] = 1'b0;
    tick(10); check("t4_fall2", btn_fall, 5'b00100);

    // 5: reset in the middle of a debounce on ch3
    btn_raw = 5'b01000;
    repeat (5) begin tick(1); check("t5_no_rise", btn_rise, 5'h00); end
    reset = 1'b1;
    tick(1);  check("t5_rst_level", btn_level, 5'h00);
    reset = 1'b0;
    tick(9);  check("t5_rise_early", btn_rise, 5'h00);
    tick(1);  check("t5_rise", btn_rise, 5'b01000);
    btn_raw = 5'h00;
    tick(10); check("t5_fall", btn_fall, 5'b01000);
    evt_ack = 5'b01000; tick(1); evt_ack = 5'h00;

    // 6: simultaneous presses on independent channels
    btn_raw = 5'b10101;
    tick(9);  check("t6_rise_early", btn_rise, 5'h00);
    tick(1);  check("t6_rise", btn_rise, 5'b10101);
              check("t6_level", btn_level, 5'b10101);
    tick(1);  check("t6_rise_done", btn_rise, 5'h00);
    btn_raw = 5'h00;
    tick(10); check("t6_fall", btn_fall, 5'b10101);
              check("t6_pend", evt_pending, 5'b10101);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
